// File: rtl/dmem_arbiter.sv
// D-SRAM access controller shared by the core load/store path and a word-wide DMA port.
// Core has priority; a starvation counter forces a DMA slot and stalls the core for that cycle.
//
// Response FSM (resp_q), describes what the SRAM read data means this cycle:
//   state         | meaning
//   RESP_NONE     | no response pending (store, idle or reset)
//   RESP_CORE_LD  | core load issued last cycle, extend and return read data
//   RESP_CORE_ERR | core access last cycle was misaligned/illegal, raise error
//   RESP_DMA_LD   | DMA read issued last cycle, return the raw word

module dmem_arbiter #(
  parameter int ADDR_W       = 10,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              clk,
  input  logic              resetn,

  input  logic              core_req_i,
  input  logic              core_we_i,
  input  logic [2:0]        core_type_i,
  input  logic [31:0]       core_addr_i,
  input  logic [31:0]       core_wdata_i,
  output logic              core_stall_o,
  output logic [31:0]       core_rdata_o,
  output logic              core_rvalid_o,
  output logic              core_misalign_o,

  input  logic              dma_req_i,
  input  logic              dma_we_i,
  input  logic [ADDR_W-1:0] dma_addr_i,
  input  logic [31:0]       dma_wdata_i,
  input  logic [3:0]        dma_wmask_i,
  output logic              dma_gnt_o,
  output logic [31:0]       dma_rdata_o,
  output logic              dma_rvalid_o,

  output logic              sram_en_o,
  output logic              sram_we_o,
  output logic [3:0]        sram_wmask_o,
  output logic [ADDR_W-1:0] sram_addr_o,
  output logic [31:0]       sram_wdata_o,
  input  logic [31:0]       sram_rdata_i
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  localparam logic [2:0] T_B  = 3'b000;
  localparam logic [2:0] T_H  = 3'b001;
  localparam logic [2:0] T_W  = 3'b010;
  localparam logic [2:0] T_BU = 3'b100;
  localparam logic [2:0] T_HU = 3'b101;

  typedef enum logic [1:0] {
    RESP_NONE,
    RESP_CORE_LD,
    RESP_CORE_ERR,
    RESP_DMA_LD
  } resp_t;

  resp_t            resp_q, resp_d;
  logic [1:0]       off_q;
  logic [2:0]       type_q;
  logic [CNT_W-1:0] starve_cnt;

  logic [1:0]  off;
  logic        legal;
  logic        force_dma;
  logic        core_gnt;
  logic        dma_gnt;
  logic        core_acc;
  logic [3:0]  st_mask;
  logic [31:0] st_data;
  logic [31:0] ld_shift;
  logic        addr_unused;

  assign off = core_addr_i[1:0];
  assign addr_unused = ^core_addr_i[31:ADDR_W+2];

  always_comb begin
    legal = 1'b0;
    case (core_type_i)
      T_B:     legal = 1'b1;
      T_BU:    legal = !core_we_i;
      T_H:     legal = !off[0];
      T_HU:    legal = !off[0] && !core_we_i;
      T_W:     legal = (off == 2'b00);
      default: legal = 1'b0;
    endcase
  end

  // Grants are masked by reset so nothing reaches the SRAM while resetn is low.
  assign force_dma    = (starve_cnt == CNT_MAX) && dma_req_i;
  assign core_gnt     = resetn && core_req_i && !force_dma;
  assign dma_gnt      = resetn && dma_req_i && (force_dma || !core_req_i);
  assign core_stall_o = resetn && core_req_i && force_dma;
  assign core_acc     = core_gnt && legal;
  assign dma_gnt_o    = dma_gnt;

  always_comb begin
    st_mask = 4'b1111;
    st_data = core_wdata_i;
    case (core_type_i[1:0])
      2'b00: begin
        st_mask = 4'b0001 << off;
        st_data = {4{core_wdata_i[7:0]}};
      end
      2'b01: begin
        st_mask = 4'b0011 << off;
        st_data = {2{core_wdata_i[15:0]}};
      end
      default: begin
        st_mask = 4'b1111;
        st_data = core_wdata_i;
      end
    endcase
  end

  always_comb begin
    sram_en_o    = 1'b0;
    sram_we_o    = 1'b0;
    sram_wmask_o = 4'b0000;
    sram_addr_o  = '0;
    sram_wdata_o = 32'h0;
    if (dma_gnt) begin
      sram_en_o    = 1'b1;
      sram_we_o    = dma_we_i;
      sram_wmask_o = dma_we_i ? dma_wmask_i : 4'b0000;
      sram_addr_o  = dma_addr_i;
      sram_wdata_o = dma_wdata_i;
    end else if (core_acc) begin
      sram_en_o    = 1'b1;
      sram_we_o    = core_we_i;
      sram_wmask_o = core_we_i ? st_mask : 4'b0000;
      sram_addr_o  = core_addr_i[ADDR_W+1:2];
      sram_wdata_o = core_we_i ? st_data : 32'h0;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      starve_cnt <= '0;
    end else if (dma_gnt || !dma_req_i) begin
      starve_cnt <= '0;
    end else if (starve_cnt != CNT_MAX) begin
      starve_cnt <= starve_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    resp_d = RESP_NONE;
    if (dma_gnt && !dma_we_i) begin
      resp_d = RESP_DMA_LD;
    end else if (core_gnt) begin
      if (!legal)
        resp_d = RESP_CORE_ERR;
      else if (!core_we_i)
        resp_d = RESP_CORE_LD;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      resp_q <= RESP_NONE;
      off_q  <= 2'b00;
      type_q <= T_W;
    end else begin
      resp_q <= resp_d;
      if (core_gnt) begin
        off_q  <= off;
        type_q <= core_type_i;
      end
    end
  end

  assign ld_shift = sram_rdata_i >> {off_q, 3'b000};

  always_comb begin
    core_rvalid_o   = 1'b0;
    core_rdata_o    = 32'h0;
    core_misalign_o = 1'b0;
    dma_rvalid_o    = 1'b0;
    dma_rdata_o     = 32'h0;
    if (resetn) begin
      case (resp_q)
        RESP_CORE_LD: begin
          core_rvalid_o = 1'b1;
          case (type_q)
            T_B:     core_rdata_o = {{24{ld_shift[7]}}, ld_shift[7:0]};
            T_H:     core_rdata_o = {{16{ld_shift[15]}}, ld_shift[15:0]};
            T_BU:    core_rdata_o = {24'h0, ld_shift[7:0]};
            T_HU:    core_rdata_o = {16'h0, ld_shift[15:0]};
            default: core_rdata_o = ld_shift;
          endcase
        end
        RESP_CORE_ERR: core_misalign_o = 1'b1;
        RESP_DMA_LD: begin
          dma_rvalid_o = 1'b1;
          dma_rdata_o  = sram_rdata_i;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Data-memory access controller that shares the single-port D-SRAM between the core's load/store path and a secondary word-wide requester (DMA / debug / interrupt context save). It performs byte-lane masking and store-data replication, extracts and extends load data, and flags misaligned accesses. Core has priority; a starvation counter guarantees the secondary port a slot and stalls the core for that cycle. It sits between the EXE→MEM boundary (request issued with the ALU address) and the MEM→WB boundary (load data returned one cycle later).

## Interface
- ADDR_W, 10, SRAM word-address width
- STARVE_LIMIT, 8, consecutive denied DMA cycles before DMA is forced a slot (≥1)
- clk  in  1  clock
- resetn  in  1  reset, synchronous, active-low
- core_req_i  in  1  core access request; held while core_stall_o=1
- core_we_i  in  1  1=store, 0=load
- core_type_i  in  3  funct3 encoding: 000 B, 001 H, 010 W, 100 BU, 101 HU
- core_addr_i  in  32  byte address
- core_wdata_i  in  32  store data, right-aligned
- core_stall_o  out  1  request present but not granted this cycle
- core_rdata_o  out  32  extended load data
- core_rvalid_o  out  1  core_rdata_o valid
- core_misalign_o  out  1  one-cycle error pulse for misaligned/illegal access
- dma_req_i  in  1  DMA request, held until dma_gnt_o
- dma_we_i  in  1  1=write
- dma_addr_i  in  ADDR_W  word address
- dma_wdata_i  in  32  write data
- dma_wmask_i  in  4  byte-lane write mask
- dma_gnt_o  out  1  DMA request accepted this cycle
- dma_rdata_o  out  32  raw read word
- dma_rvalid_o  out  1  dma_rdata_o valid
- sram_en_o  out  1  SRAM access enable
- sram_we_o  out  1  SRAM write
- sram_wmask_o  out  4  byte write enables
- sram_addr_o  out  ADDR_W  word address (core: core_addr_i[ADDR_W+1:2])
- sram_wdata_o  out  32  write data
- sram_rdata_i  in  32  read data, valid one cycle after en with we=0

## Operation
- Core access legal: B/BU any offset; H/HU addr[0]=0; W addr[1:0]=0; store only with type 000/001/010. Illegal/misaligned → no SRAM access, counts as granted (no stall), error response next cycle.
- Arbitration per cycle (combinational): force = (starve_cnt == STARVE_LIMIT) & dma_req_i. If force → DMA granted, core_stall_o = core_req_i. Else if core_req_i → core granted. Else if dma_req_i → DMA granted.
- starve_cnt: 0 on reset, on DMA grant, or when dma_req_i=0; else +1 per cycle DMA is requesting but denied; saturates at STARVE_LIMIT.
- Store masks: B 0001<<off, H 0011<<off, W 1111; wdata B {4{byte}}, H {2{half}}, W as-is.
- Response FSM register resp_q: NONE, CORE_LD, CORE_ERR, DMA_LD. Next state from the current cycle's grant: core legal load→CORE_LD, core illegal→CORE_ERR, DMA read→DMA_LD, stores/no grant→NONE. Load offset and type registered with it.
- CORE_LD: word = sram_rdata_i >> (8·off); B/H sign-extend, BU/HU zero-extend, W unchanged; core_rvalid_o=1.
- CORE_ERR: core_misalign_o=1, core_rvalid_o=0, core_rdata_o=0. DMA_LD: dma_rvalid_o=1, dma_rdata_o=sram_rdata_i.
- core_rdata_o/dma_rdata_o = 0 when not valid.

## Timing
- Accept in cycle T (same-cycle gnt / stall deassert); SRAM enable in T; read response valid throughout T+1. Back-to-back accepts every cycle, any mix of requesters.
- Stores: SRAM written at end of T; no response. Read of same word in T+1 returns new data.
- Reset: while resetn=0 all grants, sram_en_o, core_stall_o, rvalid and misalign outputs are 0; resp_q←NONE, starve_cnt←0 at the clock edge. A read accepted in the cycle before reset asserts has its response suppressed.
- Core and DMA requesting simultaneously and counter not full → core wins, DMA waits.

## Test plan
- Reset: resetn=0 with both requests high → all outputs 0; release → core granted first cycle.
- Store B 0xA5 to 0x103 → sram_wmask_o=1000, wdata 0xA5A5A5A5; LB 0x103 → core_rdata_o=0xFFFFFFA5 at T+1; LBU → 0x000000A5.
- Store H 0x8001 to 0x102, LH → 0xFFFF8001, LHU → 0x00008001; LW 0x100 after SW 0x12345678 → 0x12345678.
- LW at 0x102 → no sram_en_o, no stall, core_misalign_o pulse at T+1, rvalid 0.
- Core request every cycle + DMA read: DMA denied 8 cycles, granted on cycle 9 with core_stall_o=1, dma_rvalid_o next cycle, counter back to 0.
- Reset asserted one cycle after a core load accept → no core_rvalid_o pulse.
